mux_sel_reg: RTL

- Parametrised, registered N:1 data-source selector for the accumulator datapath. It is the next-generation replacement for the fixed 8-bit, 5-input combinational source mux.
- Adds a latched select register with range checking and a one-entry output register with valid/ready handshake.
- Adds a second arbitration mode, round-robin, that picks among valid inputs without a host-driven select.
- Sits between operand sources (ACC, memory data, immediate, I/O, ALU) and the ALU/bus consumer.

---
 rtl/mux_sel_pkg.sv | 43 ++++
 rtl/mux_rr_arb.sv | 39 +++
 rtl/mux_sel_reg.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the registered source selector: mode encodings,
// output-stage state type and the round-robin search function.
package mux_sel_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Widest configuration the round-robin search supports.
  localparam int RR_MAX_IN = 16;
  localparam int RR_IDX_W  = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // First set bit of valid searching upward from ptr, wrapping modulo n.
  // Returns {found, index}.
  function automatic logic [RR_IDX_W:0] rr_pick(
    input logic [RR_MAX_IN-1:0] valid,
    input logic [RR_IDX_W-1:0]  ptr,
    input int                   n
  );
    logic                found;
    logic [RR_IDX_W-1:0] idx;
    int                  j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < RR_MAX_IN; i++) begin
      if (i < n) begin
        j = int'(ptr) + i;
        if (j >= n) j = j - n;
        if (!found && valid[j]) begin
          found = 1'b1;
          idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/mux_rr_arb.sv
// Combinational round-robin picker: valid vector plus search pointer in,
// one-hot grant, winner index and found flag out. Holds no state.
module mux_rr_arb #(
  parameter int N_IN  = 5,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  valid_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_IN-1:0]  grant_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);
  import mux_sel_pkg::*;

  localparam logic [RR_IDX_W:0] N_LIM = (RR_IDX_W+1)'(N_IN);

  logic [RR_MAX_IN-1:0] valid_ext;
  logic [RR_IDX_W-1:0]  ptr_ext;
  logic [RR_IDX_W:0]    pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[N_IN-1:0]   = valid_i;
    ptr_ext               = '0;
    ptr_ext[SEL_W-1:0]    = ptr_i;
    pick                  = rr_pick(valid_ext, ptr_ext, N_IN);
  end

  assign idx_o = pick[SEL_W-1:0];
  // The picked index is always below N_IN; folding that in ties the full index into found_o.
  assign found_o = pick[RR_IDX_W] && ({1'b0, pick[RR_IDX_W-1:0]} < N_LIM);

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_grant
      assign grant_o[gi] = found_o && (idx_o == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/mux_sel_reg.sv
// Registered N:1 operand-source selector with latched select, round-robin mode
// and a one-entry valid/ready output register. MUX_SEL_REG_PARITY_EN adds out_parity.
module mux_sel_reg
  import mux_sel_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_IN   = 5,
  localparam int SEL_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_IN*DATA_W-1:0] in_data,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]       select,
  input  logic                   sel_load,
  input  logic                   mode,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err
`ifdef MUX_SEL_REG_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam logic [SEL_W:0]   N_IN_L   = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN-1);

  logic [DATA_W-1:0] ch_data [N_IN];
  logic [N_IN-1:0]   dir_grant;
  logic [N_IN-1:0]   rr_grant;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_found;

  out_state_e        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              sel_err_q, sel_err_d;

  logic [SEL_W-1:0]  win_idx;
  logic              win_found;
  logic              capture;
  logic              sel_in_range;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
      assign ch_data[gi]   = in_data[gi*DATA_W +: DATA_W];
      assign dir_grant[gi] = in_valid[gi] && (sel_q == SEL_W'(gi));
    end
  endgenerate

  mux_rr_arb #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_rr_arb (
    .valid_i (in_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  always_comb begin
    win_found    = 1'b0;
    win_idx      = sel_q;
    if (mode == MODE_RR) begin
      win_found = rr_found;
      win_idx   = rr_idx;
    end else begin
      win_found = in_valid[sel_q];
    end

    capture      = win_found && ((state_q == ST_EMPTY) || out_ready);

    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    ptr_d        = ptr_q;
    if (capture) begin
      state_d    = ST_FULL;
      out_data_d = ch_data[win_idx];
      out_sel_d  = win_idx;
      if (mode == MODE_RR) begin
        ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d    = ST_EMPTY;
    end

    // A load only affects captures from the next cycle on.
    sel_in_range = ({1'b0, select} < N_IN_L);
    sel_d        = (sel_load && sel_in_range) ? select : sel_q;
    sel_err_d    = sel_load && !sel_in_range;

    in_ready     = '0;
    if (capture && !reset) begin
      in_ready = (mode == MODE_RR) ? rr_grant : dir_grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      sel_q      <= '0;
      ptr_q      <= '0;
      out_sel_q  <= '0;
      out_data_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      out_sel_q  <= out_sel_d;
      out_data_q <= out_data_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_SEL_REG_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (capture) parity_d = ^ch_data[win_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end

  assign out_parity = parity_q;
`endif

endmodule
